// File: rtl/mdcfft_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mdcfft_ctrl_pkg
// Shared constants and helpers for the 8-point 2-lane MDC FFT control and
// twiddle sequencer.
//   - Stage-1 rotator select encodings (powers of W8).
//   - Q15.16 fixed-point unity.
//   - Frame length in sample pairs and the core pipeline latency.
//   - qTrig(): elaboration-time cos/sin generator for the twiddle table.
// No ports (package).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package mdcfft_ctrl_pkg;

  // Stage-1 rotator select codes: which power of W8 the core applies.
  localparam logic [1:0] ROT0_W0   = 2'b00;
  localparam logic [1:0] ROT0_W8_1 = 2'b01;
  localparam logic [1:0] ROT0_W8_2 = 2'b10;
  localparam logic [1:0] ROT0_W8_3 = 2'b11;

  // Q15.16 representation of 1.0
  localparam logic [31:0] Q_ONE = 32'h0001_0000;

  // Sample pairs per 8-point frame, and core input-to-output latency
  localparam int FRAME_LEN = 4;
  localparam int CORE_LAT  = 3;

  localparam real TWO_PI = 6.283185307179586;

  // Returns round(cos or sin(2*pi*addr/n) * 2^16) as a signed integer.
  // Only ever evaluated at elaboration to build constant tables.
  function automatic longint qTrig(input int unsigned addr,
                                   input int unsigned n,
                                   input bit          useSin);
    real ang;
    real v;
    ang = TWO_PI * real'(addr) / real'(n);
    v   = useSin ? $sin(ang) : $cos(ang);
    v   = v * real'(Q_ONE);
    // Symmetric round-half-away so negative values mirror positive ones
    if (v >= 0.0) return longint'($rtoi(v + 0.5));
    else          return -longint'($rtoi(0.5 - v));
  endfunction

endpackage

// File: rtl/mdcfft_tw_rom.sv
// -----------------------------------------------------------------------------
// mdcfft_tw_rom
// Combinational two-read-port twiddle table covering one full turn of N =
// 8*FRAMES points. Each entry is {cos, sin} in signed Q15.16, built at
// elaboration from FRAMES so the table always matches the transform size.
// Ports:
//   addr0_i  in   AW      read address, port 0
//   addr1_i  in   AW      read address, port 1
//   tw0_o    out  2*TWW   {cos,sin} at addr0_i
//   tw1_o    out  2*TWW   {cos,sin} at addr1_i
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mdcfft_tw_rom
  import mdcfft_ctrl_pkg::*;
#(
  parameter int FRAMES = 8,
  parameter int TWW    = 32,
  parameter int AW     = $clog2(8 * FRAMES)
) (
  input  logic [AW-1:0]    addr0_i,
  input  logic [AW-1:0]    addr1_i,
  output logic [2*TWW-1:0] tw0_o,
  output logic [2*TWW-1:0] tw1_o
);

  localparam int N = 8 * FRAMES;

  logic [2*TWW-1:0] tab [N];

  // One constant entry per angle; the synthesizer folds these into a ROM
  for (genvar a = 0; a < N; a++) begin : g_tab
    localparam longint C = qTrig(a, N, 1'b0);
    localparam longint S = qTrig(a, N, 1'b1);
    assign tab[a] = {C[TWW-1:0], S[TWW-1:0]};
  end

  assign tw0_o = tab[addr0_i];
  assign tw1_o = tab[addr1_i];

endmodule

// File: rtl/mdcfft_ctrl.sv
// -----------------------------------------------------------------------------
// mdcfft_ctrl
// Control and twiddle sequencer upstream of the 8-point 2-lane MDC FFT core.
// Counts sample pairs into 4-pair frames, drives the core's rotator and
// commutator selects at the right pipeline offsets, supplies the inter-frame
// twiddles for an N = 8*FRAMES two-level FFT aligned with the core outputs,
// and tags each output pair with its bin and frame index.
// Ports:
//   CLK        in   1             clock
//   RSTn       in   1             asynchronous active-low reset
//   IN_VALID   in   1             sample pair entering the core this cycle
//   SEL_ROT0   out  2             stage-1 rotator select (same cycle as input)
//   SEL_MDC0   out  1             1D commutator select (same cycle as input)
//   SEL_ROT1   out  1             stage-2 rotator select (one cycle later)
//   SEL_MDC1   out  1             2D commutator select (one cycle later)
//   TF0        out  2*TWW         {cos,sin} twiddle for output lane0
//   TF1        out  2*TWW         {cos,sin} twiddle for output lane1
//   OUT_VALID  out  1             core output pair valid
//   OUT_BIN    out  2             output pair index j, pair is (X[j], X[j+4])
//   OUT_FRAME  out  log2(FRAMES)  frame index of the output pair
//   ERR        out  1             sticky protocol error
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module mdcfft_ctrl
  import mdcfft_ctrl_pkg::*;
#(
  parameter  int FRAMES = 8,
  parameter  int TWW    = 32,
  localparam int MW     = $clog2(FRAMES)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             IN_VALID,
  output logic [1:0]       SEL_ROT0,
  output logic             SEL_MDC0,
  output logic             SEL_ROT1,
  output logic             SEL_MDC1,
  output logic [2*TWW-1:0] TF0,
  output logic [2*TWW-1:0] TF1,
  output logic             OUT_VALID,
  output logic [1:0]       OUT_BIN,
  output logic [MW-1:0]    OUT_FRAME,
  output logic             ERR
);

  localparam int AW = $clog2(8 * FRAMES);

  // Pipeline stage indices: d1, d2, d3 of the core-latency delay line
  localparam int D1 = 0;
  localparam int D2 = CORE_LAT - 2;
  localparam int D3 = CORE_LAT - 1;

  logic [1:0]       posQ, posD;
  logic [MW-1:0]    frmQ, frmD;
  logic             errQ, errD;

  logic             vldPipeQ [CORE_LAT];
  logic [1:0]       posPipeQ [CORE_LAT];
  logic [MW-1:0]    frmPipeQ [CORE_LAT];

  logic [2*TWW-1:0] tf0Q, tf1Q;

  logic [AW-1:0]    addr0, addr1;
  logic [2*TWW-1:0] tw0, tw1;

  // Position/frame counters and the protocol checker. A frame that is cut
  // short flags ERR and restarts position at 0 without advancing the frame.
  always_comb begin
    posD = posQ;
    frmD = frmQ;
    errD = errQ;
    if (IN_VALID) begin
      posD = posQ + 2'd1;
      if (posQ == 2'(FRAME_LEN - 1)) frmD = frmQ + MW'(1);
    end else begin
      posD = 2'd0;
      if (posQ != 2'd0) errD = 1'b1;
    end
  end

  // Frame index times twiddle exponent. m < FRAMES and k < 8, so the
  // product always fits in AW bits and AW-bit arithmetic is exact; the
  // natural wrap is the mod-N reduction.
  assign addr0 = AW'(frmPipeQ[D2]) * AW'({1'b0, posPipeQ[D2]});
  assign addr1 = AW'(frmPipeQ[D2]) * AW'({1'b1, posPipeQ[D2]});

  mdcfft_tw_rom #(
    .FRAMES (FRAMES),
    .TWW    (TWW),
    .AW     (AW)
  ) u_tw_rom (
    .addr0_i (addr0),
    .addr1_i (addr1),
    .tw0_o   (tw0),
    .tw1_o   (tw1)
  );

  // All sequential state. The delay line carries (valid, pos, frame) past
  // the core latency; twiddles are looked up from d2 and registered so they
  // appear alongside d3, and zero in idle slots.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      posQ <= '0;
      frmQ <= '0;
      errQ <= 1'b0;
      for (int i = 0; i < CORE_LAT; i++) begin
        vldPipeQ[i] <= 1'b0;
        posPipeQ[i] <= '0;
        frmPipeQ[i] <= '0;
      end
      tf0Q <= '0;
      tf1Q <= '0;
    end else begin
      posQ <= posD;
      frmQ <= frmD;
      errQ <= errD;
      vldPipeQ[0] <= IN_VALID;
      posPipeQ[0] <= posQ;
      frmPipeQ[0] <= frmQ;
      for (int i = 1; i < CORE_LAT; i++) begin
        vldPipeQ[i] <= vldPipeQ[i-1];
        posPipeQ[i] <= posPipeQ[i-1];
        frmPipeQ[i] <= frmPipeQ[i-1];
      end
      tf0Q <= vldPipeQ[D2] ? tw0 : '0;
      tf1Q <= vldPipeQ[D2] ? tw1 : '0;
    end
  end

  // Stage-1 rotation follows the bit-reversed input order 0,2,1,3, so
  // position p selects W8^(bitrev(p)).
  always_comb begin
    SEL_ROT0 = ROT0_W0;
    if (IN_VALID) begin
      case (posQ)
        2'd0:    SEL_ROT0 = ROT0_W0;
        2'd1:    SEL_ROT0 = ROT0_W8_2;
        2'd2:    SEL_ROT0 = ROT0_W8_1;
        default: SEL_ROT0 = ROT0_W8_3;
      endcase
    end
  end

  assign SEL_MDC0 = IN_VALID & posQ[0];

  // Stage-2 selects are forced low in idle slots so the 2D commutator
  // drains the last frame correctly.
  assign SEL_ROT1 = vldPipeQ[D1] & posPipeQ[D1][1];
  assign SEL_MDC1 = vldPipeQ[D1] & posPipeQ[D1][1];

  assign TF0       = tf0Q;
  assign TF1       = tf1Q;
  assign OUT_VALID = vldPipeQ[D3];
  assign OUT_BIN   = posPipeQ[D3];
  assign OUT_FRAME = frmPipeQ[D3];
  assign ERR       = errQ;

endmodule

// File: tb/tb_mdcfft_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdcfft_ctrl
// Directed self-checking bench for mdcfft_ctrl with FRAMES = 8 (N = 64).
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Expected twiddles are hand-computed Q15.16 constants.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mdcfft_ctrl;

  localparam int FRAMES = 8;
  localparam int TWW    = 32;

  // {cos,sin}(2*pi*a/64) * 2^16, rounded to nearest
  localparam logic [63:0] TW_ONE = 64'h00010000_00000000;
  localparam logic [63:0] TW_A1  = 64'h0000FEC4_00001918;
  localparam logic [63:0] TW_A4  = 64'h0000EC83_000061F8;
  localparam logic [63:0] TW_A5  = 64'h0000E1C6_000078AD;
  localparam logic [63:0] TW_A21 = 64'hFFFF8753_0000E1C6;
  localparam logic [63:0] TW_A49 = 64'h00001918_FFFF013C;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        IN_VALID = 1'b0;
  logic [1:0]  SEL_ROT0;
  logic        SEL_MDC0;
  logic        SEL_ROT1;
  logic        SEL_MDC1;
  logic [63:0] TF0;
  logic [63:0] TF1;
  logic        OUT_VALID;
  logic [1:0]  OUT_BIN;
  logic [2:0]  OUT_FRAME;
  logic        ERR;

  int nAsserts = 0;
  int nFails   = 0;

  logic [1:0] rotTab [4] = '{2'b00, 2'b10, 2'b01, 2'b11};

  mdcfft_ctrl #(
    .FRAMES (FRAMES),
    .TWW    (TWW)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .IN_VALID  (IN_VALID),
    .SEL_ROT0  (SEL_ROT0),
    .SEL_MDC0  (SEL_MDC0),
    .SEL_ROT1  (SEL_ROT1),
    .SEL_MDC1  (SEL_MDC1),
    .TF0       (TF0),
    .TF1       (TF1),
    .OUT_VALID (OUT_VALID),
    .OUT_BIN   (OUT_BIN),
    .OUT_FRAME (OUT_FRAME),
    .ERR       (ERR)
  );

  always #5 CLK = ~CLK;

  // Drive one cycle of input just after the rising edge, return at the
  // falling edge of the same cycle ready for sampling.
  task automatic applyStimulus(input logic v);
    @(posedge CLK);
    #1;
    IN_VALID = v;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(negedge CLK);
    IN_VALID = 1'b0;
    RSTn     = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn     = 1'b1;
  endtask

  initial begin
    // ---- Reset state ----
    repeat (2) @(negedge CLK);
    checkOutput("rst_rot0",   64'(SEL_ROT0),  64'd0);
    checkOutput("rst_mdc0",   64'(SEL_MDC0),  64'd0);
    checkOutput("rst_rot1",   64'(SEL_ROT1),  64'd0);
    checkOutput("rst_mdc1",   64'(SEL_MDC1),  64'd0);
    checkOutput("rst_tf0",    TF0,            64'd0);
    checkOutput("rst_tf1",    TF1,            64'd0);
    checkOutput("rst_ovalid", 64'(OUT_VALID), 64'd0);
    checkOutput("rst_bin",    64'(OUT_BIN),   64'd0);
    checkOutput("rst_frame",  64'(OUT_FRAME), 64'd0);
    checkOutput("rst_err",    64'(ERR),       64'd0);
    RSTn = 1'b1;

    // ---- Asynchronous reset in the middle of frame 1 ----
    for (int c = 0; c < 6; c++) applyStimulus(1'b1);
    checkOutput("mid_pre_ovalid", 64'(OUT_VALID), 64'd1);
    checkOutput("mid_pre_bin",    64'(OUT_BIN),   64'd2);
    checkOutput("mid_pre_rot0",   64'(SEL_ROT0),  64'b10);
    checkOutput("mid_pre_tf0",    TF0,            TW_ONE);
    #2;
    RSTn = 1'b0;
    #1;
    checkOutput("mid_rot0",   64'(SEL_ROT0),  64'd0);
    checkOutput("mid_ovalid", 64'(OUT_VALID), 64'd0);
    checkOutput("mid_bin",    64'(OUT_BIN),   64'd0);
    checkOutput("mid_tf0",    TF0,            64'd0);
    checkOutput("mid_tf1",    TF1,            64'd0);
    IN_VALID = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;

    // ---- Single frame, frame 0 ----
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c < 4);
      checkOutput("one_rot0", 64'(SEL_ROT0), (c < 4) ? 64'(rotTab[c]) : 64'd0);
      checkOutput("one_mdc0", 64'(SEL_MDC0), (c < 4) ? 64'(c % 2) : 64'd0);
      checkOutput("one_rot1", 64'(SEL_ROT1), (c == 3 || c == 4) ? 64'd1 : 64'd0);
      checkOutput("one_mdc1", 64'(SEL_MDC1), (c == 3 || c == 4) ? 64'd1 : 64'd0);
      checkOutput("one_ovalid", 64'(OUT_VALID), (c >= 3 && c <= 6) ? 64'd1 : 64'd0);
      checkOutput("one_tf0", TF0, (c >= 3 && c <= 6) ? TW_ONE : 64'd0);
      checkOutput("one_tf1", TF1, (c >= 3 && c <= 6) ? TW_ONE : 64'd0);
      if (c >= 3 && c <= 6) begin
        checkOutput("one_bin",   64'(OUT_BIN),   64'(c - 3));
        checkOutput("one_frame", 64'(OUT_FRAME), 64'd0);
      end
    end

    // ---- Nine back-to-back frames from a clean reset ----
    doReset();
    for (int c = 0; c < 40; c++) begin
      applyStimulus(c < 36);
      checkOutput("str_rot0", 64'(SEL_ROT0), (c < 36) ? 64'(rotTab[c % 4]) : 64'd0);
      if (c >= 3 && c < 39) begin
        checkOutput("str_ovalid", 64'(OUT_VALID), 64'd1);
        checkOutput("str_bin",    64'(OUT_BIN),   64'((c - 3) % 4));
        checkOutput("str_frame",  64'(OUT_FRAME), 64'(((c - 3) / 4) % 8));
      end else begin
        checkOutput("str_ovalid", 64'(OUT_VALID), 64'd0);
      end
      checkOutput("str_err", 64'(ERR), 64'd0);
      if (c == 7) begin
        checkOutput("tw_f1b0_tf0", TF0, TW_ONE);
        checkOutput("tw_f1b0_tf1", TF1, TW_A4);
      end
      if (c == 8) begin
        checkOutput("tw_f1b1_tf0", TF0, TW_A1);
        checkOutput("tw_f1b1_tf1", TF1, TW_A5);
      end
      if (c == 34) begin
        checkOutput("tw_f7b3_tf0", TF0, TW_A21);
        checkOutput("tw_f7b3_tf1", TF1, TW_A49);
      end
      if (c == 38) begin
        checkOutput("tw_wrap_tf0", TF0, TW_ONE);
        checkOutput("tw_wrap_tf1", TF1, TW_ONE);
      end
      if (c == 39) begin
        checkOutput("tw_idle_tf0", TF0, 64'd0);
        checkOutput("tw_idle_tf1", TF1, 64'd0);
      end
    end

    // ---- Protocol error: IN_VALID drops at p=2; frame counter is now 1 ----
    applyStimulus(1'b1);
    checkOutput("err_rot0_e0", 64'(SEL_ROT0), 64'b00);
    applyStimulus(1'b1);
    checkOutput("err_rot0_e1", 64'(SEL_ROT0), 64'b10);
    applyStimulus(1'b0);
    checkOutput("err_rot0_e2", 64'(SEL_ROT0), 64'd0);
    checkOutput("err_early",   64'(ERR),      64'd0);
    applyStimulus(1'b0);
    checkOutput("err_set",       64'(ERR),       64'd1);
    checkOutput("err_ovalid_e3", 64'(OUT_VALID), 64'd1);
    checkOutput("err_bin_e3",    64'(OUT_BIN),   64'd0);
    checkOutput("err_frame_e3",  64'(OUT_FRAME), 64'd1);
    applyStimulus(1'b1);
    checkOutput("err_restart_rot0", 64'(SEL_ROT0),  64'b00);
    checkOutput("err_sticky_e4",    64'(ERR),       64'd1);
    checkOutput("err_ovalid_e4",    64'(OUT_VALID), 64'd1);
    checkOutput("err_bin_e4",       64'(OUT_BIN),   64'd1);
    applyStimulus(1'b1);
    checkOutput("err_rot0_e5",   64'(SEL_ROT0),  64'b10);
    checkOutput("err_ovalid_e5", 64'(OUT_VALID), 64'd0);
    applyStimulus(1'b1);
    checkOutput("err_rot0_e6", 64'(SEL_ROT0), 64'b01);
    applyStimulus(1'b1);
    checkOutput("err_rot0_e7",   64'(SEL_ROT0),  64'b11);
    checkOutput("err_ovalid_e7", 64'(OUT_VALID), 64'd1);
    checkOutput("err_bin_e7",    64'(OUT_BIN),   64'd0);
    checkOutput("err_frame_e7",  64'(OUT_FRAME), 64'd1);
    checkOutput("err_tf1_e7",    TF1,            TW_A4);
    checkOutput("err_sticky_e7", 64'(ERR),       64'd1);
    applyStimulus(1'b0);
    checkOutput("err_sticky_e8", 64'(ERR), 64'd1);

    // ---- Reset clears the sticky error ----
    doReset();
    checkOutput("err_cleared", 64'(ERR), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule
